// File: rtl/vga_pkg.sv
// Shared VGA raster constants and payload types for the brick game video path.
// Holds the 640x480@60 timing, counter/colour widths and the registered
// pixel-stage payload.
package vga_pkg;

    localparam int unsigned COLOR_W = 5;
    localparam int unsigned POS_W   = 11;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    // Line/frame length is the sum of the four segments; must fit in POS_W bits.
    function automatic int unsigned total_of(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
        return vis + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL = total_of(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = total_of(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    // Palette index 0 is black; used for blanking.
    localparam logic [COLOR_W-1:0] COLOR_BLACK = '0;

    // Registered pixel-stage payload: sync levels and blanked colour.
    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic [COLOR_W-1:0] couleur;
    } pix_out_t;

endpackage

// File: rtl/sync_counter.sv
// Wrapping raster counter with raw sync decode; used for both axes.
// Ports: clk, reset (sync, active-high), enable (advance one step),
//        count (counter register), wrap (count is at TOTAL-1),
//        sync_raw (SYNC_POL while count is inside the sync window).
module sync_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_LEN   = 96,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [POS_W-1:0] count,
    output logic             wrap,
    output logic             sync_raw
);

    localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] SYNC_FIRST = POS_W'(SYNC_START);
    localparam logic [POS_W-1:0] SYNC_LAST  = POS_W'(SYNC_START + SYNC_LEN - 1);

    logic [POS_W-1:0] count_q;
    logic [POS_W-1:0] count_d;

    // Next count: hold, increment, or wrap to zero at the terminal value.
    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign wrap     = (count_q == LAST);
    assign sync_raw = ((count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: horizontal/vertical counters, blanked colour and sync
// output registers, and line/frame strobes for game logic.
// Ports: clk, reset (sync, active-high), pix_ce (pixel enable), couleur (palette
//        index for current hpos/vpos) -> hpos, vpos, visible (combinational),
//        hsync, vsync, couleur_out, line_start, frame_start (registered).
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    input  logic [COLOR_W-1:0] couleur,
    output logic [POS_W-1:0]   hpos,
    output logic [POS_W-1:0]   vpos,
    output logic               visible,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] couleur_out,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOT = total_of(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOT = total_of(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [POS_W-1:0] H_VIS = POS_W'(H_VISIBLE);
    localparam logic [POS_W-1:0] V_VIS = POS_W'(V_VISIBLE);

    localparam pix_out_t PIX_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, couleur: COLOR_BLACK};

    logic h_wrap;
    logic v_wrap;
    logic hsync_raw;
    logic vsync_raw;
    logic v_enable;

    pix_out_t pix_q;
    pix_out_t pix_d;
    logic     line_start_q;
    logic     line_start_d;
    logic     frame_start_q;
    logic     frame_start_d;

    assign v_enable = pix_ce & h_wrap;

    sync_counter #(
        .TOTAL      (H_TOT),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_hcnt (
        .clk      (clk),
        .reset    (reset),
        .enable   (pix_ce),
        .count    (hpos),
        .wrap     (h_wrap),
        .sync_raw (hsync_raw)
    );

    sync_counter #(
        .TOTAL      (V_TOT),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_vcnt (
        .clk      (clk),
        .reset    (reset),
        .enable   (v_enable),
        .count    (vpos),
        .wrap     (v_wrap),
        .sync_raw (vsync_raw)
    );

    assign visible = (hpos < H_VIS) && (vpos < V_VIS);

    // Pixel stage samples the pre-increment counters; strobes are single-clk.
    always_comb begin
        pix_d         = pix_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            pix_d.couleur = visible ? couleur : COLOR_BLACK;
            pix_d.hsync   = hsync_raw;
            pix_d.vsync   = vsync_raw;
            line_start_d  = h_wrap;
            frame_start_d = h_wrap & v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q         <= PIX_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_q         <= pix_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = pix_q.hsync;
    assign vsync       = pix_q.vsync;
    assign couleur_out = pix_q.couleur;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the 640×480 @ 60 Hz VGA raster for the brick game. It scans a horizontal counter and a vertical counter, and publishes `hpos`/`vpos` to the combinational pixel generators (frame, bricks, ball, paddle). It takes back their 5-bit palette index `couleur`, blanks it outside the visible area, and registers it together with `hsync`/`vsync` so colour and sync leave the chip aligned. It also provides frame and line strobes for game-state logic.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, active level of `hsync`/`vsync` (0 = active-low)
- `clk`  in  1  system clock; one clock domain only
- `reset`  in  1  synchronous, active-high reset
- `pix_ce`  in  1  pixel clock enable; the raster advances only on clocks where it is 1
- `couleur`  in  5  palette index from the pixel generators for the current `hpos`/`vpos`
- `hpos`  out  11  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800)
- `vpos`  out  11  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- `visible`  out  1  1 when hpos < H_VISIBLE and vpos < V_VISIBLE (combinational from counters)
- `hsync`  out  1  registered horizontal sync
- `vsync`  out  1  registered vertical sync
- `couleur_out`  out  5  registered, blanked palette index to the DAC/palette
- `line_start`  out  1  one-clk pulse, registered
- `frame_start`  out  1  one-clk pulse, registered

## Operation
- `hpos`/`vpos` are the counter registers themselves.
- Horizontal counter: on a clock with `pix_ce`=1, it increments, and wraps to 0 after H_TOTAL-1.
- Vertical counter: increments only on a horizontal wrap, and wraps to 0 after V_TOTAL-1.
- Pixel stage: on each clock with `pix_ce`=1, the block registers the following from the *pre-increment* counters and the current `couleur`:
  - `couleur_out` ← `visible` ? `couleur` : 0.
  - `hsync` ← SYNC_POL when hpos ∈ [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751]; otherwise ~SYNC_POL.
  - `vsync` ← SYNC_POL when vpos ∈ [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491]; otherwise ~SYNC_POL. `vsync` is evaluated per pixel, so it changes on the pixel where hpos=0.
- `line_start`: high for exactly one clk after a clock where `pix_ce`=1 and hpos=H_TOTAL-1.
- `frame_start`: high for exactly one clk after a clock where `pix_ce`=1, hpos=H_TOTAL-1 and vpos=V_TOTAL-1. On that event `line_start` is high in the same clk.
- `pix_ce`=0: counters, `hsync`, `vsync` and `couleur_out` hold their values; `line_start`/`frame_start` return to 0.
- Blanking is mandatory. Generators such as the border draw on vpos 477..479 for every hpos, including 640..799, so any non-zero `couleur` in blanking must not reach `couleur_out`.
- Width rules:
  - All counters and comparisons are 11-bit unsigned.
  - H_TOTAL and V_TOTAL are derived by summing the parameters; both must be ≤ 2047.

## Timing
- Reset values (`reset` wins over `pix_ce`):
  - hpos=0, vpos=0.
  - `hsync`=`vsync`=~SYNC_POL (inactive).
  - `couleur_out`=0.
  - `line_start`=`frame_start`=0.
  - `visible`=1, since it follows the counters.
- Latency: `couleur_out`, `hsync` and `vsync` lag `hpos`/`vpos` by one `pix_ce` step. The generators must be purely combinational on `hpos`/`vpos`.
- With `pix_ce` tied 1, the line period is 800 clk and the frame period is 420 000 clk.
- With `pix_ce` at 1-in-2 from a 50 MHz `clk`, the pixel rate is 25 MHz.
- Reset mid-line takes effect at the next edge. The raster restarts at (0,0) with no partial sync pulse held over.

## Structure
- Package `vga_pkg` holds:
  - the 640×480@60 timing constants;
  - `COLOR_W`=5;
  - `POS_W`=11;
  - the H_TOTAL/V_TOTAL derivation;
  - `couleur` index 0 = black.
- Sub-module `sync_counter` (parameters TOTAL, SYNC_START, SYNC_LEN, SYNC_POL; ports: `clk`, `reset`, enable, count, wrap, sync_raw). It is instantiated once for horizontal and once for vertical; the vertical instance is enabled by `pix_ce` & the horizontal wrap.
- The top level holds the output register stage and the strobes.

## Test plan
- Reset: hold `reset` 3 clk with `pix_ce`=1 → hpos=vpos=0, `hsync`=`vsync`=1, `couleur_out`=0, strobes 0.
- Line timing: `pix_ce`=1 for 1600 clk.
  - `hsync` is low for exactly 96 clk per line; the first low is the clk after hpos=656.
  - `line_start` pulses every 800 clk.
- Frame timing: run 2 frames.
  - `vsync` is low for 1600 clk, starting after (hpos=0, vpos=490).
  - `frame_start` pulses exactly once per 420 000 clk, coinciding with `line_start`.
- Blanking: drive `couleur`=20 constantly → `couleur_out`=20 only for the 640 pixels of visible lines, and 0 for hpos 640..799 and for vpos ≥ 480.
- Clock enable: `pix_ce` 1-in-2 → all periods double. On `pix_ce`=0 cycles, outputs hold and the strobes are single-clk.
- Reset mid-operation: assert `reset` at hpos=700, vpos=490 (inside vsync) → next clk `vsync`=1 and hpos=vpos=0; normal sequence resumes.
